burst_memory: RTL
=================

# burst_memory

Parametrised, cycle-accurate behavioural main-memory model that succeeds the fixed 32-bit/4-beat memory model. It supports configurable data width, depth, burst length and read latency, plus byte-enable writes, WRAP bursts, read back-pressure and request error reporting. It sits behind the cache/fetch controllers in simulation and serves both instruction and data refills.

## Interface
- DATA_W, 32: beat width in bits; must be a multiple of 8. BYTES = DATA_W/8.
- ADDR_W, 24: byte-address width; capacity is 2^ADDR_W bytes.
- MAX_BURST, 8: maximum beats per request; must be a power of 2.
- READ_LAT, 2: cycles from request acceptance to first read beat; must be ≥ 1.
- LEN_W, $clog2(MAX_BURST): width of req_len.
- clk  in  1  clock; all logic is on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when high together with req_valid.
- req_rw  in  1  0 = read, 1 = write.
- req_wrap  in  1  0 = INCR burst, 1 = WRAP burst.
- req_addr  in  ADDR_W  byte address of the first beat.
- req_len  in  LEN_W  beats minus 1.
- wr_valid  in  1  write beat present.
- wr_ready  out  1  write beat accepted when high together with wr_valid.
- wr_data  in  DATA_W  write beat data, little-endian.
- wr_strb  in  BYTES  byte enables; bit i controls byte i.
- rd_valid  out  1  read beat valid.
- rd_ready  in  1  consumer accepts the read beat.
- rd_data  out  DATA_W  read beat data, little-endian.
- rd_last  out  1  marks the final read beat.
- done  out  1  one-cycle pulse at the end of every accepted request.
- err  out  1  one-cycle pulse, coincident with done, for a rejected request.

## Operation
- States: IDLE, CHECK, RD_WAIT, RD_BEAT, WR_BEAT, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, latch rw, wrap, addr and len; go to CHECK.
- CHECK (1 cycle): validate the request.
  - Fail if addr is not BYTES-aligned.
  - Fail if req_wrap=1 and len+1 is not a power of 2.
  - Fail if INCR and addr + (len+1)*BYTES > 2^ADDR_W.
  - On failure: go to RESP with err set and no memory access.
  - Otherwise go to RD_WAIT (read) or WR_BEAT (write).
- RD_WAIT: count down so the first rd_valid rises exactly READ_LAT cycles after the acceptance edge; then go to RD_BEAT.
- RD_BEAT: rd_valid=1 and rd_data holds the word at the current address.
  - While rd_ready=0, rd_valid and rd_data stay stable.
  - On rd_valid&&rd_ready, advance the address. The next beat presents the following cycle with no bubble.
  - rd_last=1 on beat len. Its handshake moves the FSM to RESP.
- WR_BEAT: wr_ready=1.
  - Each wr_valid&&wr_ready writes the bytes enabled by wr_strb at the current address, then advances the address.
  - The handshake on beat len moves the FSM to RESP.
- RESP: done=1 (err=1 if rejected) for one cycle; return to IDLE.
- Address advance:
  - INCR: addr += BYTES.
  - WRAP: boundary = (len+1)*BYTES. Next address = (addr & ~(boundary-1)) | ((addr+BYTES) & (boundary-1)).
- Storage: byte array of 2^ADDR_W entries, initialised so byte[i] = i[7:0]. Reset does not modify storage.
- len ≥ MAX_BURST cannot be encoded, because req_len is LEN_W wide.

## Timing
- Reset (reset_n=0 at an edge): FSM goes to IDLE.
  - req_ready=0 while reset_n is low; it rises in the first cycle after release.
  - wr_ready=0, rd_valid=0, rd_last=0, rd_data=0, done=0, err=0.
- Reset mid-burst aborts the request. Beats already written persist; the remaining beats are never written.
- Read latency:
  - Acceptance at edge N; first rd_valid in the cycle after edge N+READ_LAT.
  - Minimum READ_LAT is 2, since CHECK costs one cycle. A READ_LAT of 1 behaves as 2.
- Write throughput: first wr_ready in the cycle after edge N+1; one beat per cycle thereafter.
- done follows the last beat handshake by one cycle. req_ready=0 from acceptance through RESP; it is 1 again in the cycle after done.
- wr_valid in any state other than WR_BEAT is ignored; wr_ready=0 there.

## Test plan
- Read INCR, addr=0x100, len=3, rd_ready=1, READ_LAT=2 -> rd_data 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C on consecutive cycles starting 2 cycles after acceptance; rd_last on beat 4; done 1 cycle later.
- Write addr=0x40, len=1: beat0 0xAABBCCDD strb=0b0101, beat1 0x11223344 strb=0xF; then read back len=1 -> 0x43BB41DD, 0x11223344.
- Read WRAP, addr=0x108, len=3 -> addresses 0x108, 0x10C, 0x100, 0x104; data 0x0B0A0908, 0x0F0E0D0C, 0x03020100, 0x07060504.
- rd_ready held low 3 cycles after beat 1 of a len=3 read -> rd_valid stays high, rd_data stable at beat-2 data, all 4 beats delivered in order exactly once.
- Errors:
  - addr=0x102 read -> err=done=1 in the cycle after CHECK, rd_valid never asserts.
  - WRAP len=2 -> err.
  - INCR addr=2^ADDR_W-4, len=1 -> err.
  - In all three cases storage is unchanged.
- reset_n low for 1 cycle after 2 of 4 write beats -> all outputs at reset values the next cycle; bytes of beats 0-1 updated, beats 2-3 addresses keep the init pattern; req_ready=1 in the first cycle after release.

Source files
------------

// File: rtl/burst_memory_if.sv
// Request / write-beat / read-beat bundle between a refill controller and burst_memory.
interface burst_memory_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 24,
  parameter int unsigned LEN_W  = 3
);
  localparam int unsigned BYTES = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_rw;
  logic              req_wrap;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic [BYTES-1:0]  wr_strb;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;
  logic              done;
  logic              err;

  modport master (
    output req_valid, req_rw, req_wrap, req_addr, req_len,
    output wr_valid, wr_data, wr_strb, rd_ready,
    input  req_ready, wr_ready, rd_valid, rd_data, rd_last, done, err
  );

  modport slave (
    input  req_valid, req_rw, req_wrap, req_addr, req_len,
    input  wr_valid, wr_data, wr_strb, rd_ready,
    output req_ready, wr_ready, rd_valid, rd_data, rd_last, done, err
  );
endinterface

// File: rtl/burst_memory.sv
// Cycle-accurate main-memory model: INCR/WRAP bursts, byte-enable writes,
// fixed read latency with back-pressure, and request error reporting.
module burst_memory #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 24,
  parameter int unsigned MAX_BURST = 8,
  parameter int unsigned READ_LAT  = 2,
  parameter int unsigned LEN_W     = $clog2(MAX_BURST)
) (
  input logic            clk,
  input logic            reset_n,
  burst_memory_if.slave  bus
);
  localparam int unsigned BYTES   = DATA_W / 8;
  localparam int unsigned EFF_LAT = (READ_LAT < 2) ? 2 : READ_LAT;
  localparam int unsigned CNT_W   = $clog2(EFF_LAT + 1);
  localparam int unsigned EXT_W   = ADDR_W + LEN_W + 16;
  localparam int unsigned DEPTH   = 2 ** ADDR_W;

  typedef enum logic [2:0] {IDLE, CHECK, RD_WAIT, RD_BEAT, WR_BEAT, RESP} state_e;

  state_e            state_q;
  logic              rw_q;
  logic              wrap_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  beat_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              req_ready_q;
  logic              wr_ready_q;
  logic              rd_valid_q;
  logic              rd_last_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              done_q;
  logic              err_q;
  logic              chk_fail;

  // Each cell holds the XOR delta from the power-up pattern byte[i] = i[7:0],
  // so an all-zero array reads back as that pattern.
  logic [7:0] mem_q [DEPTH];

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] w;
    logic [ADDR_W-1:0] ba;
    w = '0;
    for (int unsigned b = 0; b < BYTES; b++) begin
      ba = a + ADDR_W'(b);
      w[8*b +: 8] = mem_q[ba] ^ 8'(ba);
    end
    return w;
  endfunction

  // Next beat address for INCR or WRAP bursts
  always_comb begin
    logic [ADDR_W-1:0] mask;
    logic [ADDR_W-1:0] inc;
    mask   = ADDR_W'((32'(len_q) + 32'd1) * 32'(BYTES)) - ADDR_W'(1);
    inc    = addr_q + ADDR_W'(BYTES);
    addr_d = wrap_q ? ((addr_q & ~mask) | (inc & mask)) : inc;
  end

  // Request validation evaluated while in CHECK
  always_comb begin
    logic [LEN_W:0]   lenp1;
    logic [EXT_W-1:0] end_ext;
    logic             misalign;
    logic             not_pow2;
    logic             overflow;
    lenp1    = (LEN_W+1)'(len_q) + (LEN_W+1)'(1);
    end_ext  = EXT_W'(addr_q) + EXT_W'(lenp1) * EXT_W'(BYTES);
    misalign = (addr_q % ADDR_W'(BYTES)) != '0;
    not_pow2 = (lenp1 & (LEN_W+1)'(len_q)) != '0;
    overflow = end_ext > (EXT_W'(1) << ADDR_W);
    chk_fail = misalign | (wrap_q & not_pow2) | (~wrap_q & overflow);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rw_q        <= 1'b0;
      wrap_q      <= 1'b0;
      addr_q      <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      wr_ready_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      rd_data_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (bus.req_valid && req_ready_q) begin
            rw_q        <= bus.req_rw;
            wrap_q      <= bus.req_wrap;
            addr_q      <= bus.req_addr;
            len_q       <= bus.req_len;
            req_ready_q <= 1'b0;
            state_q     <= CHECK;
          end
        end
        CHECK: begin
          beat_q <= '0;
          if (chk_fail) begin
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            state_q <= RESP;
          end else if (rw_q) begin
            wr_ready_q <= 1'b1;
            state_q    <= WR_BEAT;
          end else begin
            cnt_q   <= CNT_W'(EFF_LAT - 2);
            state_q <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (cnt_q == '0) begin
            rd_valid_q <= 1'b1;
            rd_data_q  <= mem_word(addr_q);
            rd_last_q  <= (len_q == '0);
            state_q    <= RD_BEAT;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RD_BEAT: begin
          if (bus.rd_ready) begin
            if (rd_last_q) begin
              rd_valid_q <= 1'b0;
              rd_last_q  <= 1'b0;
              rd_data_q  <= '0;
              done_q     <= 1'b1;
              state_q    <= RESP;
            end else begin
              addr_q    <= addr_d;
              beat_q    <= beat_q + LEN_W'(1);
              rd_data_q <= mem_word(addr_d);
              rd_last_q <= ((beat_q + LEN_W'(1)) == len_q);
            end
          end
        end
        WR_BEAT: begin
          if (bus.wr_valid) begin
            if (beat_q == len_q) begin
              wr_ready_q <= 1'b0;
              done_q     <= 1'b1;
              state_q    <= RESP;
            end else begin
              addr_q <= addr_d;
              beat_q <= beat_q + LEN_W'(1);
            end
          end
        end
        RESP: begin
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Storage is deliberately outside reset: an aborted burst keeps its written beats
  always_ff @(posedge clk) begin
    if (reset_n && (state_q == WR_BEAT) && bus.wr_valid) begin
      for (int unsigned b = 0; b < BYTES; b++) begin
        if (bus.wr_strb[b]) begin
          mem_q[addr_q + ADDR_W'(b)] <= bus.wr_data[8*b +: 8] ^ 8'(addr_q + ADDR_W'(b));
        end
      end
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.wr_ready  = wr_ready_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_last   = rd_last_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
endmodule
